char_action_fsm: RTL

- Parametrised next-generation character action state machine for the fighting-game core. It sits between the inverted key inputs and the sprite/hitbox/movement logic.
- Adds four things over the current handler:
  - frame-tick gating, so the FSM advances once per video frame;
  - exact, parameterised phase durations;
  - hitstun entered on an incoming hit;
  - rising-edge attack detection with an input buffer during recovery.

---
 rtl/char_pkg.sv | 27 ++
 rtl/char_phase_timer.sv | 39 +++
 rtl/char_action_fsm.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/char_pkg.sv
// Shared state codes and default frame lengths for the character action core,
// the sprite block and the hitbox block.
package char_pkg;

   typedef logic [3:0] char_state_t;

   localparam char_state_t S_IDLE       = 4'd0;
   localparam char_state_t S_LEFT       = 4'd1;
   localparam char_state_t S_RIGHT      = 4'd2;
   localparam char_state_t S_ATK_START  = 4'd3;
   localparam char_state_t S_ATK_ACTIVE = 4'd4;
   localparam char_state_t S_ATK_RECOV  = 4'd5;
   localparam char_state_t S_DIR_START  = 4'd6;
   localparam char_state_t S_DIR_ACTIVE = 4'd7;
   localparam char_state_t S_DIR_RECOV  = 4'd8;
   localparam char_state_t S_HITSTUN    = 4'd9;

   localparam int unsigned DEF_ATK_START_FRAMES  = 5;
   localparam int unsigned DEF_ATK_ACTIVE_FRAMES = 2;
   localparam int unsigned DEF_ATK_RECOV_FRAMES  = 16;
   localparam int unsigned DEF_DIR_START_FRAMES  = 4;
   localparam int unsigned DEF_DIR_ACTIVE_FRAMES = 3;
   localparam int unsigned DEF_DIR_RECOV_FRAMES  = 15;
   localparam int unsigned DEF_HITSTUN_FRAMES    = 10;
   localparam int unsigned DEF_BUF_FRAMES        = 4;

endpackage

// File: rtl/char_phase_timer.sv
// Down-counter for timed action phases; advances only on frame ticks and a
// load takes priority over the decrement. Saturates at zero.
module char_phase_timer #(
   parameter int unsigned CW = 5
) (
   input  logic          CLOCK,
   input  logic          RESET,
   input  logic          tick,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   output logic [CW-1:0] cnt,
   output logic          zero
);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (tick) begin
         if (load) begin
            cnt_d = load_val;
         end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
         end
      end
   end

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign zero = (cnt_q == '0);

endmodule

// File: rtl/char_action_fsm.sv
// Character action state machine: tick-gated movement, timed neutral and
// directional attacks, hitstun on incoming hits and a recovery attack buffer.
module char_action_fsm
   import char_pkg::*;
#(
   parameter int unsigned CW                = 5,
   parameter int unsigned ATK_START_FRAMES  = DEF_ATK_START_FRAMES,
   parameter int unsigned ATK_ACTIVE_FRAMES = DEF_ATK_ACTIVE_FRAMES,
   parameter int unsigned ATK_RECOV_FRAMES  = DEF_ATK_RECOV_FRAMES,
   parameter int unsigned DIR_START_FRAMES  = DEF_DIR_START_FRAMES,
   parameter int unsigned DIR_ACTIVE_FRAMES = DEF_DIR_ACTIVE_FRAMES,
   parameter int unsigned DIR_RECOV_FRAMES  = DEF_DIR_RECOV_FRAMES,
   parameter int unsigned HITSTUN_FRAMES    = DEF_HITSTUN_FRAMES,
   parameter int unsigned BUF_FRAMES        = DEF_BUF_FRAMES
) (
   input  logic          CLOCK,
   input  logic          RESET,
   input  logic          FRAME_TICK,
   input  logic          KEY_LEFT,
   input  logic          KEY_RIGHT,
   input  logic          KEY_ATTACK,
   input  logic          HIT_IN,
   output logic [3:0]    STATE,
   output logic [CW-1:0] FRAME_CNT,
   output logic          ATTACK_ACTIVE,
   output logic          ATTACK_DIR,
   output logic          STATE_CHG
);

   localparam logic [CW-1:0] LD_ATK_START  = CW'(ATK_START_FRAMES - 1);
   localparam logic [CW-1:0] LD_ATK_ACTIVE = CW'(ATK_ACTIVE_FRAMES - 1);
   localparam logic [CW-1:0] LD_ATK_RECOV  = CW'(ATK_RECOV_FRAMES - 1);
   localparam logic [CW-1:0] LD_DIR_START  = CW'(DIR_START_FRAMES - 1);
   localparam logic [CW-1:0] LD_DIR_ACTIVE = CW'(DIR_ACTIVE_FRAMES - 1);
   localparam logic [CW-1:0] LD_DIR_RECOV  = CW'(DIR_RECOV_FRAMES - 1);
   localparam logic [CW-1:0] LD_HITSTUN    = CW'(HITSTUN_FRAMES - 1);

   char_state_t   state_q, state_d;
   logic          atk_prev_q, atk_prev_d;
   logic          buf_q, buf_d;
   logic          attack_active_q, attack_active_d;
   logic          attack_dir_q, attack_dir_d;
   logic          state_chg_q, state_chg_d;

   logic          tmr_load;
   logic [CW-1:0] tmr_load_val;
   logic [CW-1:0] tmr_cnt;
   logic          tmr_zero;

   logic          atk_edge;
   logic          mv_left;
   logic          mv_right;
   logic          in_buf_win;

   assign atk_edge   = KEY_ATTACK & ~atk_prev_q;
   assign mv_left    = KEY_LEFT & ~KEY_RIGHT;
   assign mv_right   = KEY_RIGHT & ~KEY_LEFT;
   assign in_buf_win = (32'(tmr_cnt) < BUF_FRAMES);

   char_phase_timer #(
      .CW(CW)
   ) u_timer (
      .CLOCK   (CLOCK),
      .RESET   (RESET),
      .tick    (FRAME_TICK),
      .load    (tmr_load),
      .load_val(tmr_load_val),
      .cnt     (tmr_cnt),
      .zero    (tmr_zero)
   );

   always_comb begin
      state_d      = state_q;
      atk_prev_d   = atk_prev_q;
      buf_d        = buf_q;
      tmr_load     = 1'b0;
      tmr_load_val = '0;

      if (FRAME_TICK) begin
         atk_prev_d = KEY_ATTACK;
         if (HIT_IN) begin
            state_d      = S_HITSTUN;
            tmr_load     = 1'b1;
            tmr_load_val = LD_HITSTUN;
            buf_d        = 1'b0;
         end else begin
            case (state_q)
               S_IDLE, S_LEFT, S_RIGHT: begin
                  // Untimed states keep the counter pinned at zero.
                  tmr_load = 1'b1;
                  if (atk_edge || buf_q) begin
                     buf_d = 1'b0;
                     if (mv_left || mv_right) begin
                        state_d      = S_DIR_START;
                        tmr_load_val = LD_DIR_START;
                     end else begin
                        state_d      = S_ATK_START;
                        tmr_load_val = LD_ATK_START;
                     end
                  end else if (mv_left) begin
                     state_d = S_LEFT;
                  end else if (mv_right) begin
                     state_d = S_RIGHT;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
               S_ATK_START: if (tmr_zero) begin
                  state_d      = S_ATK_ACTIVE;
                  tmr_load     = 1'b1;
                  tmr_load_val = LD_ATK_ACTIVE;
               end
               S_ATK_ACTIVE: if (tmr_zero) begin
                  state_d      = S_ATK_RECOV;
                  tmr_load     = 1'b1;
                  tmr_load_val = LD_ATK_RECOV;
               end
               S_DIR_START: if (tmr_zero) begin
                  state_d      = S_DIR_ACTIVE;
                  tmr_load     = 1'b1;
                  tmr_load_val = LD_DIR_ACTIVE;
               end
               S_DIR_ACTIVE: if (tmr_zero) begin
                  state_d      = S_DIR_RECOV;
                  tmr_load     = 1'b1;
                  tmr_load_val = LD_DIR_RECOV;
               end
               S_ATK_RECOV, S_DIR_RECOV: begin
                  // The flag is consumed by IDLE on the tick after recovery ends.
                  if (atk_edge && in_buf_win) begin
                     buf_d = 1'b1;
                  end
                  if (tmr_zero) begin
                     state_d  = S_IDLE;
                     tmr_load = 1'b1;
                  end
               end
               S_HITSTUN: if (tmr_zero) begin
                  state_d  = S_IDLE;
                  tmr_load = 1'b1;
               end
               default: begin
                  state_d  = S_IDLE;
                  tmr_load = 1'b1;
               end
            endcase
         end
      end

      attack_active_d = (state_d == S_ATK_ACTIVE) || (state_d == S_DIR_ACTIVE);
      attack_dir_d    = (state_d == S_DIR_START) || (state_d == S_DIR_ACTIVE) ||
                        (state_d == S_DIR_RECOV);
      state_chg_d     = FRAME_TICK && (state_d != state_q);
   end

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state_q         <= S_IDLE;
         atk_prev_q      <= 1'b0;
         buf_q           <= 1'b0;
         attack_active_q <= 1'b0;
         attack_dir_q    <= 1'b0;
         state_chg_q     <= 1'b0;
      end else begin
         state_q         <= state_d;
         atk_prev_q      <= atk_prev_d;
         buf_q           <= buf_d;
         attack_active_q <= attack_active_d;
         attack_dir_q    <= attack_dir_d;
         state_chg_q     <= state_chg_d;
      end
   end

   assign STATE         = state_q;
   assign FRAME_CNT     = tmr_cnt;
   assign ATTACK_ACTIVE = attack_active_q;
   assign ATTACK_DIR    = attack_dir_q;
   assign STATE_CHG     = state_chg_q;

endmodule
